// File: rtl/comp_pixel_packer_if.sv
// comp_pixel_packer_if: sample-in / packed-word-out handshake bundle for comp_pixel_packer (flush pins exist only with PACK_FLUSH_EN)
interface comp_pixel_packer_if #(
  parameter int COMP_WIDTH = 8,
  parameter int PACK = 4,
  parameter int LCNT_WIDTH = 16
);
  logic in_valid;
  logic in_ready;
  logic [COMP_WIDTH-1:0] comp_in;
  logic out_valid;
  logic out_ready;
  logic [COMP_WIDTH*PACK-1:0] out_data;
  logic out_last;
  logic [LCNT_WIDTH-1:0] line_count;
`ifdef PACK_FLUSH_EN
  logic flush;
  logic flush_ack;
  modport master (output in_valid, comp_in, out_ready, flush, input in_ready, out_valid, out_data, out_last, line_count, flush_ack);
  modport slave (input in_valid, comp_in, out_ready, flush, output in_ready, out_valid, out_data, out_last, line_count, flush_ack);
`else
  modport master (output in_valid, comp_in, out_ready, input in_ready, out_valid, out_data, out_last, line_count);
  modport slave (input in_valid, comp_in, out_ready, output in_ready, out_valid, out_data, out_last, line_count);
`endif
endinterface

// File: rtl/comp_pixel_packer.sv
// comp_pixel_packer: packs PACK compressed samples per output word, flags line ends, counts lines.
// Optional partial-word flush via `define PACK_FLUSH_EN.
module comp_pixel_packer #(
  parameter int COMP_WIDTH = 8,
  parameter int PACK = 4,
  parameter int LINE_LEN = 256,
  parameter int LCNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  comp_pixel_packer_if.slave bus
);
  localparam int CNT_W = $clog2(PACK);
  localparam int COL_W = $clog2(LINE_LEN);
  localparam int ASM_W = COMP_WIDTH * (PACK - 1);
  logic [CNT_W-1:0] cnt_q;
  logic [COL_W-1:0] col_q;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [COMP_WIDTH*PACK-1:0] data_q;
  logic valid_q, last_q;
  logic [LCNT_WIDTH-1:0] line_q;
  logic full, col_end, drain, accept, xfer, flush_go, load;
  assign full = cnt_q == CNT_W'(PACK - 1);
  assign col_end = col_q == COL_W'(LINE_LEN - 1);
  assign drain = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign xfer = valid_q && bus.out_ready;
`ifdef PACK_FLUSH_EN
  logic flush_ack_q;
  // the ack cycle blocks re-service while the driver is still holding flush
  assign flush_go = bus.flush && drain && !flush_ack_q;
  assign bus.in_ready = !bus.flush && (!full || drain);
  assign bus.flush_ack = flush_ack_q;
  always_ff @(posedge clk)
    flush_ack_q <= reset ? 1'b0 : flush_go;
`else
  assign flush_go = 1'b0;
  assign bus.in_ready = !full || drain;
`endif
  assign load = (accept && full) || (flush_go && cnt_q != '0);
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < PACK - 1; i++)
      if (cnt_q == CNT_W'(i)) asm_d[i*COMP_WIDTH +: COMP_WIDTH] = bus.comp_in;
  end
  // assembly is cleared after every word so unfilled lanes of a flushed word read as zero
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      col_q <= '0;
      asm_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      line_q <= '0;
    end else begin
      if (accept) begin
        cnt_q <= full ? '0 : cnt_q + 1'b1;
        col_q <= col_end ? '0 : col_q + 1'b1;
        asm_q <= full ? '0 : asm_d;
      end else if (flush_go) begin
        cnt_q <= '0;
        col_q <= '0;
        asm_q <= '0;
      end
      if (load) begin
        data_q <= flush_go ? {{COMP_WIDTH{1'b0}}, asm_q} : {bus.comp_in, asm_q};
        last_q <= flush_go || col_end;
        valid_q <= 1'b1;
      end else if (xfer) valid_q <= 1'b0;
      if (xfer && last_q) line_q <= line_q + 1'b1;
    end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_last = last_q;
  assign bus.line_count = line_q;
endmodule

// File: tb/tb_comp_pixel_packer.sv
// tb_comp_pixel_packer: directed bench for comp_pixel_packer (PACK=4, LINE_LEN=8); flush test with PACK_FLUSH_EN.
module tb_comp_pixel_packer;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0, stalls = 0, acks = 0;
  logic [32:0] got[$];
  comp_pixel_packer_if #(.COMP_WIDTH(8), .PACK(4), .LCNT_WIDTH(16)) bus ();
  comp_pixel_packer #(.COMP_WIDTH(8), .PACK(4), .LINE_LEN(8), .LCNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_data});
    if (!reset && bus.in_valid && !bus.in_ready) stalls++;
`ifdef PACK_FLUSH_EN
    if (!reset && bus.flush_ack) acks++;
`endif
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] s);
    bus.in_valid = 1'b1;
    bus.comp_in = s;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (n == 49) check("send_timeout", 0, 1);
    end
    cyc();
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.comp_in = '0;
    bus.out_ready = 1'b1;
`ifdef PACK_FLUSH_EN
    bus.flush = 1'b0;
`endif
    cyc(2);
    reset = 1'b0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_lines", bus.line_count, 0);
    check("rst_ready", bus.in_ready, 1);
    stalls = 0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    check("s1_valid", bus.out_valid, 1);
    check("s1_data", bus.out_data, 64'h04030201);
    check("s1_last", bus.out_last, 0);
    for (int i = 5; i <= 8; i++) send(8'(i));
    check("s2_data", bus.out_data, 64'h08070605);
    check("s2_last", bus.out_last, 1);
    cyc();
    check("s_words", got.size(), 2);
    check("s_w0", got[0], {1'b0, 32'h04030201});
    check("s_w1", got[1], {1'b1, 32'h08070605});
    check("s_lines", bus.line_count, 1);
    check("s_idle", bus.out_valid, 0);
    check("s_stalls", stalls, 0);
    got.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(8'h10 + 8'(i));
    check("bp_data", bus.out_data, 64'h13121110);
    bus.in_valid = 1'b1;
    bus.comp_in = 8'h17;
    cyc(3);
    @(negedge clk);
    check("bp_stall", bus.in_ready, 0);
    check("bp_hold_valid", bus.out_valid, 1);
    check("bp_hold_data", bus.out_data, 64'h13121110);
    check("bp_hold_last", bus.out_last, 0);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("bp_words", got.size(), 1);
    check("bp_w0", got[0], {1'b0, 32'h13121110});
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_data", bus.out_data, 64'h17161514);
    check("bp_next_last", bus.out_last, 1);
    check("bp_lines1", bus.line_count, 1);
    bus.out_ready = 1'b1;
    cyc();
    check("bp_lines2", bus.line_count, 2);
    got.delete();
    for (int i = 0; i < 24; i++) send(8'h20 + 8'(i));
    cyc();
    check("lw_words", got.size(), 6);
    for (int w = 0; w < 6; w++) begin
      logic [7:0] b;
      b = 8'h20 + 8'(4 * w);
      check($sformatf("lw_w%0d", w), got[w], {w % 2 == 1, b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    check("lw_lines", bus.line_count, 5);
    got.delete();
    send(8'hAA);
    cyc(5);
    check("gap_novalid", bus.out_valid, 0);
    check("gap_nowords", got.size(), 0);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    cyc();
    check("gap_words", got.size(), 1);
    check("gap_w0", got[0], {1'b0, 32'hDDCCBBAA});
    send(8'h01);
    send(8'h02);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    got.delete();
    check("mr_lines", bus.line_count, 0);
    check("mr_valid", bus.out_valid, 0);
    for (int i = 5; i <= 8; i++) send(8'(i));
    cyc();
    check("mr_words", got.size(), 1);
    check("mr_w0", got[0], {1'b0, 32'h08070605});
    check("mr_lines2", bus.line_count, 0);
`ifdef PACK_FLUSH_EN
    got.delete();
    acks = 0;
    send(8'h11);
    send(8'h22);
    bus.flush = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.flush_ack) break;
      if (n == 19) check("fl_timeout", 0, 1);
    end
    cyc();
    bus.flush = 1'b0;
    cyc(3);
    check("fl_acks", acks, 1);
    check("fl_w0", got[0], {1'b1, 32'h00002211});
    check("fl_lines", bus.line_count, 1);
    for (int i = 0; i < 4; i++) send(8'h33 + 8'(17 * i));
    cyc();
    check("fl_words", got.size(), 2);
    check("fl_w1", got[1], {1'b0, 32'h66554433});
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/comp_pixel_packer.md
Name: comp_pixel_packer

Overview:
- Receiving end of the compressed-sample stream from the log-compression post-processor.
- Accepts one COMP_WIDTH sample per valid/ready handshake and packs PACK samples into one wide word for the frame/display writer.
- Tracks position within a scan line, flags the word that closes each line, and counts completed lines.
- Assembly and output registers are decoupled, so throughput is 1 sample/cycle when downstream is ready.

Parameters:
- COMP_WIDTH, 8, bits per compressed sample.
- PACK, 4, samples per output word (>=2).
- LINE_LEN, 256, samples per scan line; must be a multiple of PACK.
- LCNT_WIDTH, 16, width of the completed-line counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  packer can accept a sample (combinational).
- comp_in  input  COMP_WIDTH  compressed sample.
- out_valid  output  1  packed word valid (registered).
- out_ready  input  1  downstream accepts word.
- out_data  output  COMP_WIDTH*PACK  packed word; first-received sample in bits [COMP_WIDTH-1:0].
- out_last  output  1  word contains the final sample of a line.
- line_count  output  LCNT_WIDTH  completed lines transferred; wraps.

Behaviour:
- Reset is synchronous. It clears the assembly register, sample counter cnt (0..PACK-1) and column counter col (0..LINE_LEN-1). Output values after reset: out_valid=0, out_data=0, out_last=0, line_count=0.
- Reset mid-operation discards any partial word and any held output word.
- Input accept = in_valid && in_ready.
- in_ready = (cnt != PACK-1) || !out_valid || out_ready. Only the word-completing sample stalls, and only while the output register is occupied and not draining.
- Accept with cnt < PACK-1:
  - comp_in is written to lane cnt of the assembly register.
  - cnt++ and col++.
- Accept with cnt == PACK-1 (word complete):
  - On the next edge, out_data <= {comp_in, assembly lanes PACK-2..0}.
  - out_valid <= 1.
  - out_last <= (col == LINE_LEN-1).
  - cnt <= 0; col <= (col == LINE_LEN-1) ? 0 : col+1.
  - Latency: word visible the cycle after its last sample is accepted.
- Output transfer = out_valid && out_ready.
  - Transfer with no simultaneous load: out_valid <= 0. out_data and out_last hold their values.
  - Transfer and load in the same cycle: the new word replaces the old one and out_valid stays 1. No bubble, no loss.
- line_count increments on each transfer with out_last=1, wrapping at 2^LCNT_WIDTH.
- While out_valid=1 and out_ready=0, out_data and out_last must stay stable.
- in_valid=0 never alters cnt or col. Partial words persist indefinitely.
- Sample order is preserved; nothing is dropped or duplicated.

Optional Feature:
- Macro: PACK_FLUSH_EN.
- When defined, two extra ports exist:
  - flush  input  1  level request to emit the partial word.
  - flush_ack  output  1  one-cycle pulse when the flush is serviced.
- While flush=1, in_ready=0 and no sample is accepted.
- The flush is serviced in the first cycle with !out_valid || out_ready:
  - If cnt != 0: load the partial word (lanes >= cnt zero-filled), out_valid <= 1, out_last <= 1.
  - Always: cnt <= 0, col <= 0, flush_ack <= 1 for one cycle.
- The driver deasserts flush after seeing flush_ack.
- When the macro is undefined, neither port exists and partial words wait for more samples.

Test Plan (PACK=4, LINE_LEN=8, COMP_WIDTH=8):
- Streaming: feed 0x01..0x08 with in_valid=1 and out_ready=1 held high. Expect words 0x04030201 (out_last=0) then 0x08070605 (out_last=1), each 1 cycle after its 4th sample. in_ready stays 1 throughout; line_count=1.
- Backpressure: out_ready=0 while feeding 0x10..0x17. Expect word 0x13121110 held stable. 0x14..0x16 are accepted, then in_ready=0 with 0x17 pending. Raising out_ready for 1 cycle transfers 0x13121110 and accepts 0x17; next word is 0x17161514 with out_last=1.
- Line wrap: feed 24 samples. Expect out_last on words 2, 4 and 6; line_count 1→2→3; col returns to 0 each line.
- Idle gaps: feed 0xAA, idle 5 cycles, then 0xBB, 0xCC, 0xDD. Expect a single word 0xDDCCBBAA; no spurious out_valid.
- Reset mid-word: feed 0x01,0x02, pulse reset, then feed 0x05..0x08. Expect word 0x08070605 with out_last=0 and line_count=0.
- PACK_FLUSH_EN: feed 0x11,0x22, then assert flush. Expect word 0x00002211 with out_last=1 and a single flush_ack pulse. The next sample 0x33 lands in lane 0 of a new line.
